cache_axi_rd_arbiter: RTL and testbench
=======================================

CACHE_AXI_RD_ARBITER -- requirements
Module: cache_axi_rd_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16, meaning beats per refill burst (arlen = LINE_WORDS-1).
REQ-002 SHALL have parameter ICACHE_ID, default 4'd0, meaning AXI arid used for icache refills.
REQ-003 SHALL have parameter DCACHE_ID, default 4'd1, meaning AXI arid used for dcache refills.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 mem_iaddr_req  input  1  icache refill request, held until mem_iaddr_ok.
REQ-007 mem_addr  input  32  icache refill address.
REQ-008 mem_iaddr_ok  output  1  icache address accepted by AXI.
REQ-009 mem_idata_ok  output  1  icache beat valid.
REQ-010 mem_inst_rdata  output  32  icache beat data.
REQ-011 mem_idata_rlast  output  1  icache final beat.
REQ-012 mem_daddr_req, mem_daddr, mem_daddr_ok, mem_ddata_ok, mem_data_rdata, mem_ddata_rlast  same directions/widths as REQ-006..011, dcache port.
REQ-013 arid 4 / araddr 32 / arlen 8 / arsize 3 / arburst 2 / arvalid 1  outputs  AXI AR channel.
REQ-014 arready  input  1  AXI AR ready.
REQ-015 rid 4 / rdata 32 / rlast 1 / rvalid 1  inputs; rready 1  output  AXI R channel.
REQ-016 protocol_err  output  1  sticky error flag.

Function
REQ-017 States SHALL be IDLE, ADDR, DATA; one outstanding burst at a time.
REQ-018 IDLE: on any requester req, SHALL register grant, address, id and enter ADDR next cycle; no req -> stay IDLE.
REQ-019 Both reqs in same IDLE cycle: grant the port not granted last (round-robin via last_grant register; reset value = icache, so dcache wins first tie).
REQ-020 ADDR: arvalid=1, araddr/arid held stable from register until arready; arlen=LINE_WORDS-1, arsize=3'b010, arburst=2'b01 (INCR) constant.
REQ-021 Granted port's addr_ok SHALL equal arvalid & arready (same cycle); other port's addr_ok 0; then enter DATA.
REQ-022 Requester dropping req while in ADDR SHALL NOT retract arvalid; burst completes, data still steered to that port.
REQ-023 DATA: rready=1; granted port's data_ok = rvalid & (rid == granted id); rdata forwarded combinationally to both rdata outputs; non-granted data_ok 0.
REQ-024 Beat counter (width clog2(LINE_WORDS)+1) SHALL reset to 0 on entry to DATA and increment on each accepted beat.
REQ-025 Granted rlast output = rvalid & rlast & id match.
REQ-026 Accepted beat with rlast SHALL return FSM to IDLE next cycle; new grant possible in that IDLE cycle (min 1 idle cycle between bursts).
REQ-027 protocol_err SHALL set on: rvalid with rid mismatch in DATA; rlast before beat LINE_WORDS-1; beat LINE_WORDS-1 without rlast; rvalid outside DATA.
REQ-028 Mismatched-rid beats SHALL be accepted (rready=1) and dropped, not counted.
REQ-029 Beat LINE_WORDS-1 without rlast: stay in DATA until rlast, counter saturates.
REQ-030 Latency: req at cycle N in IDLE -> arvalid at N+1; arready at N+1 -> first beat earliest N+2.

Reset
REQ-031 rst low SHALL immediately force IDLE, arvalid=0, rready=0, araddr=0, arid=0, counter=0, last_grant=icache, protocol_err=0, all *_ok and rlast outputs 0.
REQ-032 Reset mid-burst SHALL abandon burst; no further data_ok until a new grant.

Verification
REQ-033 Icache only, mem_addr=0x1FC0_0040, arready 1 cycle later, 16 beats rid=0 -> arvalid/araddr=0x1FC00040/arlen=15, mem_iaddr_ok one pulse, 16 mem_idata_ok, rlast on 16th, back to IDLE.
REQ-034 Both req same cycle after reset -> dcache granted arid=1; after its burst icache granted arid=0; third tie -> dcache.
REQ-035 arready held low 5 cycles with icache req dropped in cycle 2 -> araddr stable, burst still completes to icache port.
REQ-036 rlast on beat 10 -> protocol_err=1 sticky, FSM returns IDLE; beat with rid=2 during icache burst -> no data_ok, protocol_err=1.
REQ-037 rst asserted at beat 7 of dcache burst -> outputs zero immediately; after release icache req served normally.
REQ-038 rvalid gaps (every other cycle) -> data_ok only on valid cycles, 16 beats counted, no error.

Source files
------------

// File: rtl/cache_axi_rd_arbiter_if.sv
// ============================================================================
// Module   : cache_axi_rd_arbiter_if
// Brief    : AXI read address / read data channel bundle for the refill arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_axi_rd_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rlast, rvalid,
        input  rready
    );
endinterface

`default_nettype wire

// File: rtl/cache_axi_rd_arbiter.sv
// ============================================================================
// Module   : cache_axi_rd_arbiter
// Brief    : Round-robin arbiter sharing one AXI read port between icache and
//            dcache line refills, one outstanding burst at a time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_axi_rd_arbiter #(
    parameter int         LINE_WORDS = 16,
    parameter logic [3:0] ICACHE_ID  = 4'd0,
    parameter logic [3:0] DCACHE_ID  = 4'd1
) (
    input  wire logic        clk,
    input  wire logic        rst,

    input  wire logic        mem_iaddr_req,
    input  wire logic [31:0] mem_addr,
    output logic             mem_iaddr_ok,
    output logic             mem_idata_ok,
    output logic [31:0]      mem_inst_rdata,
    output logic             mem_idata_rlast,

    input  wire logic        mem_daddr_req,
    input  wire logic [31:0] mem_daddr,
    output logic             mem_daddr_ok,
    output logic             mem_ddata_ok,
    output logic [31:0]      mem_data_rdata,
    output logic             mem_ddata_rlast,

    cache_axi_rd_arbiter_if.master axi,

    output logic             protocol_err
);

    localparam int               CNT_W     = $clog2(LINE_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    logic             grant_d;       // 1 = dcache owns the current burst
    logic             last_grant_d;  // 1 = dcache was granted most recently
    logic [31:0]      araddr_q;
    logic [3:0]       arid_q;
    logic             arvalid_q;
    logic             rready_q;
    logic [CNT_W-1:0] beat_cnt;

    logic             pick_d;
    logic             id_match;
    logic             beat_ok;
    logic             err_now;

    // On a tie the port that did not win last time takes the bus.
    assign pick_d   = mem_daddr_req & (~mem_iaddr_req | ~last_grant_d);

    assign id_match = (axi.rid == arid_q);
    assign beat_ok  = rready_q & axi.rvalid & id_match;

    assign err_now  = (axi.rvalid & (state != DATA))
                    | (rready_q & axi.rvalid & ~id_match)
                    | (beat_ok &  axi.rlast & (beat_cnt <  LAST_BEAT))
                    | (beat_ok & ~axi.rlast & (beat_cnt >= LAST_BEAT));

    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign mem_iaddr_ok    = arvalid_q & axi.arready & ~grant_d;
    assign mem_daddr_ok    = arvalid_q & axi.arready &  grant_d;
    assign mem_idata_ok    = beat_ok & ~grant_d;
    assign mem_ddata_ok    = beat_ok &  grant_d;
    assign mem_idata_rlast = beat_ok & axi.rlast & ~grant_d;
    assign mem_ddata_rlast = beat_ok & axi.rlast &  grant_d;
    assign mem_inst_rdata  = axi.rdata;
    assign mem_data_rdata  = axi.rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant_d      <= 1'b0;
            last_grant_d <= 1'b0;
            araddr_q     <= 32'd0;
            arid_q       <= 4'd0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            beat_cnt     <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (err_now) begin
                protocol_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mem_iaddr_req | mem_daddr_req) begin
                        grant_d      <= pick_d;
                        last_grant_d <= pick_d;
                        araddr_q     <= pick_d ? mem_daddr : mem_addr;
                        arid_q       <= pick_d ? DCACHE_ID : ICACHE_ID;
                        arvalid_q    <= 1'b1;
                        state        <= ADDR;
                    end
                end
                ADDR: begin
                    // The address stays posted even if the requester withdraws.
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat_ok) begin
                        if (beat_cnt != CNT_SAT) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (axi.rlast) begin
                            rready_q <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_axi_rd_arbiter.sv
// ============================================================================
// Module   : tb_cache_axi_rd_arbiter
// Brief    : Directed self-checking bench for cache_axi_rd_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_axi_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        mem_iaddr_req;
    logic [31:0] mem_addr;
    logic        mem_iaddr_ok;
    logic        mem_idata_ok;
    logic [31:0] mem_inst_rdata;
    logic        mem_idata_rlast;
    logic        mem_daddr_req;
    logic [31:0] mem_daddr;
    logic        mem_daddr_ok;
    logic        mem_ddata_ok;
    logic [31:0] mem_data_rdata;
    logic        mem_ddata_rlast;
    logic        protocol_err;

    int n_cmp = 0;
    int n_bad = 0;

    cache_axi_rd_arbiter_if ax ();

    cache_axi_rd_arbiter #(
        .LINE_WORDS (16),
        .ICACHE_ID  (4'd0),
        .DCACHE_ID  (4'd1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_iaddr_req   (mem_iaddr_req),
        .mem_addr        (mem_addr),
        .mem_iaddr_ok    (mem_iaddr_ok),
        .mem_idata_ok    (mem_idata_ok),
        .mem_inst_rdata  (mem_inst_rdata),
        .mem_idata_rlast (mem_idata_rlast),
        .mem_daddr_req   (mem_daddr_req),
        .mem_daddr       (mem_daddr),
        .mem_daddr_ok    (mem_daddr_ok),
        .mem_ddata_ok    (mem_ddata_ok),
        .mem_data_rdata  (mem_data_rdata),
        .mem_ddata_rlast (mem_ddata_rlast),
        .axi             (ax),
        .protocol_err    (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after a rising edge; outputs are read 4 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_iaddr_req = 1'b0;
        mem_addr      = 32'd0;
        mem_daddr_req = 1'b0;
        mem_daddr     = 32'd0;
        ax.arready    = 1'b0;
        ax.rvalid     = 1'b0;
        ax.rid        = 4'd0;
        ax.rdata      = 32'd0;
        ax.rlast      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic run_beats(input int n, input logic [3:0] id, input int last_at,
                             input bit gaps, input logic [31:0] base,
                             output int iok, output int dok, output int ilast,
                             output int dlast, output int dbad);
        iok = 0; dok = 0; ilast = 0; dlast = 0; dbad = 0;
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                ax.rvalid = 1'b0;
                ax.rlast  = 1'b0;
                #4;
                if (mem_idata_ok || mem_ddata_ok) dbad++;
                tick();
            end
            ax.rvalid = 1'b1;
            ax.rid    = id;
            ax.rdata  = base + 32'(k);
            ax.rlast  = (k == last_at);
            #4;
            if (mem_idata_ok) begin
                iok++;
                if (mem_inst_rdata !== base + 32'(k)) dbad++;
            end
            if (mem_ddata_ok) begin
                dok++;
                if (mem_data_rdata !== base + 32'(k)) dbad++;
            end
            if (mem_idata_rlast) ilast++;
            if (mem_ddata_rlast) dlast++;
            if (mem_iaddr_ok || mem_daddr_ok) dbad++;
            tick();
        end
        ax.rvalid = 1'b0;
        ax.rlast  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        #4;
        n_cmp++; if (ax.arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_arvalid: got %b want 0", ax.arvalid); end
        n_cmp++; if (ax.rready !== 1'b0) begin n_bad++; $display("FAIL reset_rready: got %b want 0", ax.rready); end
        n_cmp++; if (ax.araddr !== 32'd0 || ax.arid !== 4'd0) begin n_bad++; $display("FAIL reset_ar: got addr %h id %h want 0/0", ax.araddr, ax.arid); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", protocol_err); end
        n_cmp++; if ({mem_iaddr_ok, mem_idata_ok, mem_idata_rlast, mem_daddr_ok, mem_ddata_ok, mem_ddata_rlast} !== 6'b0) begin
            n_bad++; $display("FAIL reset_oks: got %b want 000000", {mem_iaddr_ok, mem_idata_ok, mem_idata_rlast, mem_daddr_ok, mem_ddata_ok, mem_ddata_rlast});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_icache_burst();
        int iok, dok, il, dl, db;
        mem_iaddr_req = 1'b1;
        mem_addr      = 32'h1FC0_0040;
        #4;
        n_cmp++; if (ax.arvalid !== 1'b0) begin n_bad++; $display("FAIL ic_arvalid_early: got %b want 0", ax.arvalid); end
        tick();
        ax.arready = 1'b1;
        #4;
        n_cmp++; if (ax.arvalid !== 1'b1) begin n_bad++; $display("FAIL ic_arvalid: got %b want 1", ax.arvalid); end
        n_cmp++; if (ax.araddr !== 32'h1FC0_0040 || ax.arid !== 4'd0) begin n_bad++; $display("FAIL ic_ar: got addr %h id %h want 1fc00040/0", ax.araddr, ax.arid); end
        n_cmp++; if (ax.arlen !== 8'd15 || ax.arsize !== 3'b010 || ax.arburst !== 2'b01) begin
            n_bad++; $display("FAIL ic_arfields: got len %0d size %b burst %b want 15/010/01", ax.arlen, ax.arsize, ax.arburst);
        end
        n_cmp++; if (mem_iaddr_ok !== 1'b1 || mem_daddr_ok !== 1'b0) begin n_bad++; $display("FAIL ic_addr_ok: got i %b d %b want 1/0", mem_iaddr_ok, mem_daddr_ok); end
        tick();
        ax.arready    = 1'b0;
        mem_iaddr_req = 1'b0;
        run_beats(16, 4'd0, 15, 1'b0, 32'hA000_0000, iok, dok, il, dl, db);
        #4;
        n_cmp++; if (iok !== 16 || dok !== 0) begin n_bad++; $display("FAIL ic_beats: got i %0d d %0d want 16/0", iok, dok); end
        n_cmp++; if (il !== 1 || dl !== 0 || db !== 0) begin n_bad++; $display("FAIL ic_last_data: got ilast %0d dlast %0d bad %0d want 1/0/0", il, dl, db); end
        n_cmp++; if (ax.rready !== 1'b0 || ax.arvalid !== 1'b0) begin n_bad++; $display("FAIL ic_idle: got rready %b arvalid %b want 0/0", ax.rready, ax.arvalid); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL ic_err: got %b want 0", protocol_err); end
        tick();
    endtask

    task automatic test_round_robin();
        int iok, dok, il, dl, db;
        do_reset();
        mem_iaddr_req = 1'b1; mem_addr  = 32'h0000_1000;
        mem_daddr_req = 1'b1; mem_daddr = 32'h8000_2000;
        #4;
        tick();
        ax.arready = 1'b1;
        #4;
        n_cmp++; if (ax.arid !== 4'd1 || ax.araddr !== 32'h8000_2000) begin n_bad++; $display("FAIL rr_first: got id %h addr %h want 1/80002000", ax.arid, ax.araddr); end
        n_cmp++; if (mem_daddr_ok !== 1'b1 || mem_iaddr_ok !== 1'b0) begin n_bad++; $display("FAIL rr_first_ok: got d %b i %b want 1/0", mem_daddr_ok, mem_iaddr_ok); end
        tick();
        ax.arready    = 1'b0;
        mem_daddr_req = 1'b0;
        run_beats(16, 4'd1, 15, 1'b0, 32'hD000_0000, iok, dok, il, dl, db);
        n_cmp++; if (dok !== 16 || iok !== 0 || dl !== 1 || db !== 0) begin
            n_bad++; $display("FAIL rr_dburst: got d %0d i %0d dlast %0d bad %0d want 16/0/1/0", dok, iok, dl, db);
        end
        #4;
        n_cmp++; if (ax.arvalid !== 1'b0) begin n_bad++; $display("FAIL rr_gap: got arvalid %b want 0", ax.arvalid); end
        tick();
        ax.arready = 1'b1;
        #4;
        n_cmp++; if (ax.arid !== 4'd0 || ax.araddr !== 32'h0000_1000 || mem_iaddr_ok !== 1'b1) begin
            n_bad++; $display("FAIL rr_second: got id %h addr %h iok %b want 0/00001000/1", ax.arid, ax.araddr, mem_iaddr_ok);
        end
        tick();
        ax.arready    = 1'b0;
        mem_iaddr_req = 1'b0;
        run_beats(16, 4'd0, 15, 1'b0, 32'h1000_0000, iok, dok, il, dl, db);
        n_cmp++; if (iok !== 16 || dok !== 0 || db !== 0) begin n_bad++; $display("FAIL rr_iburst: got i %0d d %0d bad %0d want 16/0/0", iok, dok, db); end
        mem_iaddr_req = 1'b1; mem_addr  = 32'h0000_3000;
        mem_daddr_req = 1'b1; mem_daddr = 32'h8000_4000;
        #4;
        tick();
        #4;
        n_cmp++; if (ax.arid !== 4'd1 || ax.araddr !== 32'h8000_4000) begin n_bad++; $display("FAIL rr_third: got id %h addr %h want 1/80004000", ax.arid, ax.araddr); end
        do_reset();
    endtask

    task automatic test_addr_stall();
        int iok, dok, il, dl, db;
        mem_iaddr_req = 1'b1;
        mem_addr      = 32'h0040_0080;
        #4;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 1) mem_iaddr_req = 1'b0;
            #4;
            n_cmp++; if (ax.arvalid !== 1'b1 || ax.araddr !== 32'h0040_0080 || mem_iaddr_ok !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold%0d: got arvalid %b addr %h iok %b want 1/00400080/0", k, ax.arvalid, ax.araddr, mem_iaddr_ok);
            end
            tick();
        end
        ax.arready = 1'b1;
        #4;
        n_cmp++; if (mem_iaddr_ok !== 1'b1) begin n_bad++; $display("FAIL stall_ok: got %b want 1", mem_iaddr_ok); end
        tick();
        ax.arready = 1'b0;
        run_beats(16, 4'd0, 15, 1'b0, 32'h5000_0000, iok, dok, il, dl, db);
        n_cmp++; if (iok !== 16 || dok !== 0 || il !== 1 || db !== 0) begin
            n_bad++; $display("FAIL stall_burst: got i %0d d %0d ilast %0d bad %0d want 16/0/1/0", iok, dok, il, db);
        end
    endtask

    task automatic test_rvalid_gaps();
        int iok, dok, il, dl, db;
        mem_iaddr_req = 1'b1;
        mem_addr      = 32'h0000_0100;
        #4;
        tick();
        ax.arready = 1'b1;
        #4;
        tick();
        ax.arready    = 1'b0;
        mem_iaddr_req = 1'b0;
        run_beats(16, 4'd0, 15, 1'b1, 32'h6000_0000, iok, dok, il, dl, db);
        #4;
        n_cmp++; if (iok !== 16 || il !== 1 || db !== 0) begin n_bad++; $display("FAIL gaps_burst: got i %0d ilast %0d bad %0d want 16/1/0", iok, il, db); end
        n_cmp++; if (protocol_err !== 1'b0 || ax.rready !== 1'b0) begin n_bad++; $display("FAIL gaps_end: got err %b rready %b want 0/0", protocol_err, ax.rready); end
        tick();
    endtask

    task automatic test_early_rlast();
        int iok, dok, il, dl, db;
        do_reset();
        mem_iaddr_req = 1'b1;
        mem_addr      = 32'h0000_0200;
        #4;
        tick();
        ax.arready = 1'b1;
        #4;
        tick();
        ax.arready    = 1'b0;
        mem_iaddr_req = 1'b0;
        run_beats(10, 4'd0, 9, 1'b0, 32'h7000_0000, iok, dok, il, dl, db);
        #4;
        n_cmp++; if (iok !== 10 || il !== 1) begin n_bad++; $display("FAIL early_beats: got i %0d ilast %0d want 10/1", iok, il); end
        n_cmp++; if (protocol_err !== 1'b1 || ax.rready !== 1'b0) begin n_bad++; $display("FAIL early_err: got err %b rready %b want 1/0", protocol_err, ax.rready); end
        tick();
        tick();
        tick();
        #4;
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL early_sticky: got %b want 1", protocol_err); end
        tick();
    endtask

    task automatic test_rid_mismatch();
        int iok, dok, il, dl, db;
        do_reset();
        mem_iaddr_req = 1'b1;
        mem_addr      = 32'h0000_0300;
        #4;
        tick();
        ax.arready = 1'b1;
        #4;
        tick();
        ax.arready    = 1'b0;
        mem_iaddr_req = 1'b0;
        ax.rvalid = 1'b1; ax.rid = 4'd2; ax.rdata = 32'hDEAD_BEEF; ax.rlast = 1'b0;
        #4;
        n_cmp++; if (mem_idata_ok !== 1'b0 || mem_ddata_ok !== 1'b0 || ax.rready !== 1'b1) begin
            n_bad++; $display("FAIL rid_drop: got iok %b dok %b rready %b want 0/0/1", mem_idata_ok, mem_ddata_ok, ax.rready);
        end
        tick();
        ax.rvalid = 1'b0;
        #4;
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL rid_err: got %b want 1", protocol_err); end
        tick();
        run_beats(16, 4'd0, 15, 1'b0, 32'h9000_0000, iok, dok, il, dl, db);
        n_cmp++; if (iok !== 16 || il !== 1 || db !== 0) begin n_bad++; $display("FAIL rid_burst: got i %0d ilast %0d bad %0d want 16/1/0", iok, il, db); end
    endtask

    task automatic test_reset_mid_burst();
        int iok, dok, il, dl, db;
        do_reset();
        mem_daddr_req = 1'b1;
        mem_daddr     = 32'h8000_0100;
        #4;
        tick();
        ax.arready = 1'b1;
        #4;
        tick();
        ax.arready    = 1'b0;
        mem_daddr_req = 1'b0;
        run_beats(6, 4'd1, -1, 1'b0, 32'hB000_0000, iok, dok, il, dl, db);
        n_cmp++; if (dok !== 6) begin n_bad++; $display("FAIL mid_pre: got d %0d want 6", dok); end
        ax.rvalid = 1'b1; ax.rid = 4'd1; ax.rdata = 32'hB000_0006;
        rst = 1'b0;
        #4;
        n_cmp++; if (mem_ddata_ok !== 1'b0 || mem_ddata_rlast !== 1'b0 || ax.rready !== 1'b0 || ax.arvalid !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_out: got dok %b dlast %b rready %b arvalid %b want 0/0/0/0", mem_ddata_ok, mem_ddata_rlast, ax.rready, ax.arvalid);
        end
        n_cmp++; if (ax.araddr !== 32'd0 || ax.arid !== 4'd0 || protocol_err !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_regs: got addr %h id %h err %b want 0/0/0", ax.araddr, ax.arid, protocol_err);
        end
        tick();
        ax.rvalid = 1'b0;
        rst = 1'b1;
        tick();
        mem_iaddr_req = 1'b1;
        mem_addr      = 32'h0000_0400;
        #4;
        tick();
        ax.arready = 1'b1;
        #4;
        n_cmp++; if (ax.arid !== 4'd0 || ax.araddr !== 32'h0000_0400 || mem_iaddr_ok !== 1'b1) begin
            n_bad++; $display("FAIL mid_regrant: got id %h addr %h iok %b want 0/00000400/1", ax.arid, ax.araddr, mem_iaddr_ok);
        end
        tick();
        ax.arready    = 1'b0;
        mem_iaddr_req = 1'b0;
        run_beats(16, 4'd0, 15, 1'b0, 32'hC000_0000, iok, dok, il, dl, db);
        #4;
        n_cmp++; if (iok !== 16 || dok !== 0 || db !== 0 || protocol_err !== 1'b0) begin
            n_bad++; $display("FAIL mid_after: got i %0d d %0d bad %0d err %b want 16/0/0/0", iok, dok, db, protocol_err);
        end
        tick();
    endtask

    task automatic test_stray_rvalid();
        do_reset();
        ax.rvalid = 1'b1; ax.rid = 4'd0; ax.rdata = 32'h1234_5678;
        #4;
        n_cmp++; if (mem_idata_ok !== 1'b0 || ax.rready !== 1'b0) begin n_bad++; $display("FAIL stray_ok: got iok %b rready %b want 0/0", mem_idata_ok, ax.rready); end
        tick();
        ax.rvalid = 1'b0;
        #4;
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL stray_err: got %b want 1", protocol_err); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_icache_burst();
        test_round_robin();
        test_addr_stall();
        test_rvalid_gaps();
        test_early_rlast();
        test_rid_mismatch();
        test_reset_mid_burst();
        test_stray_rvalid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
